// File: rtl/fetch_target_queue_pkg.sv
// ============================================================================
// Module  : fetch_target_queue_pkg
// Brief   : Shared types and sizes for the fetch target queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_target_queue_pkg;

    localparam int ADDR_W       = 32;
    localparam int FTQ_N        = 2;
    localparam int FTQ_DEPTH    = 8;
    localparam int FTQ_IDX_BITS = $clog2(FTQ_DEPTH);

    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        addr_t pc;
        logic  taken;
    } pc_entry_t;

    typedef struct packed {
        logic  valid;
        addr_t pc;
        logic  pred_taken;
        addr_t pred_target;
    } ftq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_target_queue_if.sv
// ============================================================================
// Module  : fetch_target_queue_if
// Brief   : Predictor, redirect and fetch-side signals of the fetch target queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_target_queue_if
    import fetch_target_queue_pkg::*;
#(
    parameter int N     = FTQ_N,
    parameter int DEPTH = FTQ_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int REQ_W = $clog2(N + 1);

    pc_entry_t  [N-1:0]  pred_target;
    logic                pred_valid;
    addr_t               pc_start;
    logic                pred_ready;
    logic                flush;
    addr_t               redirect_pc;
    logic   [REQ_W-1:0]  deq_req;
    ftq_entry_t [N-1:0]  deq_entries;
    logic   [REQ_W-1:0]  deq_count;
    logic   [CNT_W-1:0]  count;

    modport slave (
        input  pred_target, pred_valid, flush, redirect_pc, deq_req,
        output pc_start, pred_ready, deq_entries, deq_count, count
    );

    modport master (
        output pred_target, pred_valid, flush, redirect_pc, deq_req,
        input  pc_start, pred_ready, deq_entries, deq_count, count
    );

endinterface

`default_nettype wire

// File: rtl/fetch_target_queue_ptr_ctrl.sv
// ============================================================================
// Module  : fetch_target_queue_ptr_ctrl
// Brief   : Head/tail/occupancy bookkeeping, ready and pop-count for the FTQ.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_target_queue_ptr_ctrl #(
    parameter  int N     = 2,
    parameter  int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int REQ_W = $clog2(N + 1)
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             i_pred_valid,
    input  wire logic             i_flush,
    input  wire logic [REQ_W-1:0] i_deq_req,
    output logic      [IDX_W-1:0] o_head,
    output logic      [IDX_W-1:0] o_tail,
    output logic      [CNT_W-1:0] o_count,
    output logic                  o_pred_ready,
    output logic                  o_enq_fire,
    output logic      [REQ_W-1:0] o_deq_count
);

    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_req_ext;
    logic [CNT_W-1:0] w_deq_ext;
    logic [CNT_W-1:0] w_count_next;

    // Ready looks only at the pre-dequeue occupancy.
    assign o_pred_ready = (CNT_W'(DEPTH) - r_count) >= CNT_W'(N);
    assign o_enq_fire   = i_pred_valid && o_pred_ready && !i_flush;

    assign w_req_ext    = CNT_W'(i_deq_req);
    assign w_deq_ext    = i_flush ? '0 : ((w_req_ext < r_count) ? w_req_ext : r_count);
    assign o_deq_count  = REQ_W'(w_deq_ext);
    assign w_count_next = r_count + (o_enq_fire ? CNT_W'(N) : '0) - w_deq_ext;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + IDX_W'(w_deq_ext);
            if (o_enq_fire) begin
                r_tail <= r_tail + IDX_W'(N);
            end
            r_count <= w_count_next;
        end
    end

    assign o_head  = r_head;
    assign o_tail  = r_tail;
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_target_queue.sv
// ============================================================================
// Module  : fetch_target_queue
// Brief   : Fetch PC register plus circular queue of predicted fetch targets.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_target_queue
    import fetch_target_queue_pkg::*;
#(
    parameter int    N        = FTQ_N,
    parameter int    DEPTH    = FTQ_DEPTH,
    parameter addr_t RESET_PC = '0
) (
    input  wire logic      clock,
    input  wire logic      reset,
    fetch_target_queue_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int REQ_W = $clog2(N + 1);

    ftq_entry_t       r_queue [DEPTH];
    addr_t            r_pc_start;
    addr_t            w_src_pc [N];
    ftq_entry_t       w_new [N];
    logic [IDX_W-1:0] w_head;
    logic [IDX_W-1:0] w_tail;
    logic [CNT_W-1:0] w_count;
    logic             w_pred_ready;
    logic             w_enq_fire;
    logic [REQ_W-1:0] w_deq_count;

    fetch_target_queue_ptr_ctrl #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clock        (clock),
        .reset        (reset),
        .i_pred_valid (bus.pred_valid),
        .i_flush      (bus.flush),
        .i_deq_req    (bus.deq_req),
        .o_head       (w_head),
        .o_tail       (w_tail),
        .o_count      (w_count),
        .o_pred_ready (w_pred_ready),
        .o_enq_fire   (w_enq_fire),
        .o_deq_count  (w_deq_count)
    );

    // Each slot's own PC is the previous slot's predicted target.
    for (genvar gi = 0; gi < N; gi++) begin : g_src_pc
        if (gi == 0) begin : g_first
            assign w_src_pc[gi] = r_pc_start;
        end else begin : g_chain
            assign w_src_pc[gi] = bus.pred_target[gi-1].pc;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_new[i] = '{valid:       1'b1,
                         pc:          w_src_pc[i],
                         pred_taken:  bus.pred_target[i].taken,
                         pred_target: bus.pred_target[i].pc};
        end
    end

    always_ff @(posedge clock) begin
        if (w_enq_fire) begin
            for (int i = 0; i < N; i++) begin
                r_queue[w_tail + IDX_W'(i)] <= w_new[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc_start <= RESET_PC;
        end else if (bus.flush) begin
            r_pc_start <= bus.redirect_pc;
        end else if (w_enq_fire) begin
            r_pc_start <= bus.pred_target[N-1].pc;
        end
    end

    // Slots beyond the occupancy read as all-zero so stale storage never leaks.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.deq_entries[i] = '0;
            if (CNT_W'(i) < w_count) begin
                bus.deq_entries[i] = r_queue[w_head + IDX_W'(i)];
            end
        end
    end

    assign bus.pc_start   = r_pc_start;
    assign bus.pred_ready = w_pred_ready;
    assign bus.deq_count  = w_deq_count;
    assign bus.count      = w_count;

endmodule

`default_nettype wire
